ntt_job_scheduler: RTL and testbench

NTT_JOB_SCHEDULER -- requirements
Module: ntt_job_scheduler

---
 rtl/ntt_job_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_ntt_job_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_job_scheduler.sv
// Sequences one NTT job: stream ROWS host rows into the core, start it, wait for done,
// then read the rows back through a 2-entry credit-limited FIFO to the output stream.
module ntt_job_scheduler #(
   parameter int ROWS    = 8,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8224,
   parameter int MEM_LAT = 2,
   parameter int TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [5:0]        job_mod_idx,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              ntt_start,
   output logic [5:0]        ntt_mod_idx,
   output logic              ntt_mem_write,
   output logic              ntt_mem_read,
   output logic [ADDR_W-1:0] ntt_row_addr,
   input  logic [DATA_W-1:0] ntt_dout,
   input  logic              ntt_done,
   output logic              busy,
   output logic              err_timeout
);

   localparam int CNT_W = $clog2(ROWS + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_UNLOAD} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [5:0]         r_mod_idx;
   logic [CNT_W-1:0]   r_row_cnt;
   logic [CNT_W-1:0]   r_iss_cnt;
   logic [TMR_W-1:0]   r_timer;
   logic               r_err;
   logic [MEM_LAT-1:0] r_fl_vld;
   logic [MEM_LAT-1:0] r_fl_last;
   logic [1:0]         r_fifo_cnt;
   logic [DATA_W-1:0]  r_fifo_data [2];
   logic [1:0]         r_fifo_last;

   logic               w_issue;
   logic               w_issue_last;
   logic               w_push;
   logic               w_push_last;
   logic               w_pop;
   logic               w_pop_last;
   logic               w_timeout;
   logic [2:0]         w_occ;

   function automatic logic [1:0] count_inflight(input logic [MEM_LAT-1:0] v);
      logic [1:0] n;
      n = 2'd0;
      for (int i = 0; i < MEM_LAT; i++) n = n + {1'b0, v[i]};
      return n;
   endfunction

   // Credits cover both buffered rows and reads still in the memory pipeline.
   assign w_occ        = {1'b0, r_fifo_cnt} + {1'b0, count_inflight(r_fl_vld)};
   assign w_issue      = (r_state == S_UNLOAD) && (r_iss_cnt < CNT_W'(ROWS)) && (w_occ < 3'd2);
   assign w_issue_last = (r_iss_cnt == CNT_W'(ROWS - 1));
   assign w_push       = r_fl_vld[MEM_LAT-1];
   assign w_push_last  = r_fl_last[MEM_LAT-1];
   assign out_valid    = (r_fifo_cnt != 2'd0);
   assign out_data     = r_fifo_data[0];
   assign out_last     = out_valid & r_fifo_last[0];
   assign w_pop        = out_valid & out_ready;
   assign w_pop_last   = w_pop & r_fifo_last[0];
   assign w_timeout    = (r_state == S_RUN) && !ntt_done && (r_timer == TMR_W'(TIMEOUT - 1));

   assign ntt_mem_read = w_issue;
   assign ntt_mod_idx  = r_mod_idx;
   assign busy         = (r_state != S_IDLE);
   assign err_timeout  = r_err;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      job_ready     = 1'b0;
      in_ready      = 1'b0;
      ntt_start     = 1'b0;
      ntt_mem_write = 1'b0;
      ntt_row_addr  = '0;
      case (r_state)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) w_next = S_LOAD;
         end
         S_LOAD: begin
            in_ready      = 1'b1;
            ntt_mem_write = in_valid;
            ntt_row_addr  = ADDR_W'(r_row_cnt);
            if (in_valid && (r_row_cnt == CNT_W'(ROWS - 1))) w_next = S_START;
         end
         S_START: begin
            ntt_start = 1'b1;
            w_next    = S_RUN;
         end
         S_RUN: begin
            // A done level seen in START is never looked at; only RUN samples it.
            if (ntt_done)       w_next = S_UNLOAD;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_UNLOAD: begin
            ntt_row_addr = ADDR_W'(r_iss_cnt);
            if (w_pop_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mod_idx  <= '0;
         r_row_cnt  <= '0;
         r_iss_cnt  <= '0;
         r_timer    <= '0;
         r_err      <= 1'b0;
         r_fl_vld   <= '0;
         r_fl_last  <= '0;
         r_fifo_cnt <= 2'd0;
      end else begin
         if ((r_state == S_IDLE) && job_valid) begin
            r_mod_idx <= job_mod_idx;
            r_row_cnt <= '0;
            r_err     <= 1'b0;
         end
         if ((r_state == S_LOAD) && in_valid) r_row_cnt <= r_row_cnt + CNT_W'(1);
         if (r_state == S_START) r_timer <= '0;
         if (r_state == S_RUN)   r_timer <= r_timer + TMR_W'(1);
         if (w_timeout) r_err <= 1'b1;
         if ((r_state == S_RUN) && ntt_done) r_iss_cnt <= '0;
         if (w_issue) r_iss_cnt <= r_iss_cnt + CNT_W'(1);
         r_fl_vld[0]  <= w_issue;
         r_fl_last[0] <= w_issue & w_issue_last;
         for (int i = 1; i < MEM_LAT; i++) begin
            r_fl_vld[i]  <= r_fl_vld[i-1];
            r_fl_last[i] <= r_fl_last[i-1];
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
         if (w_pop_last) begin
            r_fifo_cnt <= 2'd0;
            r_fl_vld   <= '0;
         end
      end
   end

   // FIFO storage: entry 0 is always the head, entry 1 the tail when two are held.
   always_ff @(posedge clk) begin
      if (w_push) begin
         if (w_pop) begin
            if (r_fifo_cnt == 2'd2) begin
               r_fifo_data[0] <= r_fifo_data[1];
               r_fifo_last[0] <= r_fifo_last[1];
               r_fifo_data[1] <= ntt_dout;
               r_fifo_last[1] <= w_push_last;
            end else begin
               r_fifo_data[0] <= ntt_dout;
               r_fifo_last[0] <= w_push_last;
            end
         end else if (r_fifo_cnt == 2'd0) begin
            r_fifo_data[0] <= ntt_dout;
            r_fifo_last[0] <= w_push_last;
         end else begin
            r_fifo_data[1] <= ntt_dout;
            r_fifo_last[1] <= w_push_last;
         end
      end else if (w_pop) begin
         r_fifo_data[0] <= r_fifo_data[1];
         r_fifo_last[0] <= r_fifo_last[1];
      end
   end

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Bench for ntt_job_scheduler: a row memory with fixed read latency stands in for the
// NTT core; result rows are expected to be host row + modulus index, in address order.
module tb_ntt_job_scheduler;

   localparam int ROWS = 8;
   localparam int DW   = 64;

   logic clk, reset;
   logic job_valid, job_ready, in_valid, in_ready, out_valid, out_ready, out_last;
   logic ntt_start, ntt_mem_write, ntt_mem_read, ntt_done, busy, err_timeout;
   logic [5:0]    job_mod_idx, ntt_mod_idx;
   logic [7:0]    ntt_row_addr;
   logic [DW-1:0] out_data, ntt_dout, din;

   logic b_job_valid, b_job_ready, b_in_valid, b_in_ready, b_out_valid, b_out_last;
   logic b_ntt_start, b_ntt_mem_write, b_ntt_mem_read, b_busy, b_err_timeout;
   logic [5:0]    b_job_mod_idx, b_ntt_mod_idx;
   logic [7:0]    b_ntt_row_addr;
   logic [DW-1:0] b_out_data;
   logic          b_ntt_done, b_out_ready;
   logic [DW-1:0] b_ntt_dout;

   assign b_ntt_done  = 1'b0;
   assign b_out_ready = 1'b1;
   assign b_ntt_dout  = '0;

   ntt_job_scheduler #(.ROWS(ROWS), .ADDR_W(8), .DATA_W(DW), .MEM_LAT(2), .TIMEOUT(200)) dut (
      .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
      .job_mod_idx(job_mod_idx), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .ntt_start(ntt_start), .ntt_mod_idx(ntt_mod_idx), .ntt_mem_write(ntt_mem_write),
      .ntt_mem_read(ntt_mem_read), .ntt_row_addr(ntt_row_addr), .ntt_dout(ntt_dout),
      .ntt_done(ntt_done), .busy(busy), .err_timeout(err_timeout));

   ntt_job_scheduler #(.ROWS(ROWS), .ADDR_W(8), .DATA_W(DW), .MEM_LAT(2), .TIMEOUT(20)) dut_to (
      .clk(clk), .reset(reset), .job_valid(b_job_valid), .job_ready(b_job_ready),
      .job_mod_idx(b_job_mod_idx), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .ntt_start(b_ntt_start), .ntt_mod_idx(b_ntt_mod_idx),
      .ntt_mem_write(b_ntt_mem_write), .ntt_mem_read(b_ntt_mem_read),
      .ntt_row_addr(b_ntt_row_addr), .ntt_dout(b_ntt_dout), .ntt_done(b_ntt_done),
      .busy(b_busy), .err_timeout(b_err_timeout));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core memory model: writes land immediately, reads return two cycles after issue.
   logic [DW-1:0] mem [256];
   logic          rv_p0, rv_p1;
   logic [7:0]    ra_p0, ra_p1;
   logic [5:0]    rm_p0, rm_p1;
   int            starts;
   always @(posedge clk) begin
      if (ntt_mem_write) mem[ntt_row_addr] <= din;
      if (reset) begin
         rv_p0 <= 1'b0; rv_p1 <= 1'b0; starts <= 0;
      end else begin
         rv_p0 <= ntt_mem_read; rv_p1 <= rv_p0;
         if (ntt_start) starts <= starts + 1;
      end
      ra_p0 <= ntt_row_addr; ra_p1 <= ra_p0;
      rm_p0 <= ntt_mod_idx;  rm_p1 <= rm_p0;
   end
   assign ntt_dout = rv_p1 ? (mem[ra_p1] + DW'(rm_p1)) : 64'hBAD0_BAD0_BAD0_BAD0;

   int n_pass = 0, n_total = 0;
   logic [DW-1:0] host [ROWS];

   typedef struct {
      logic [5:0] mod;
      int         delay;
      bit         early;
      int         rmode;
      bit         gaps;
      int         exp_rows;
      bit         exp_err;
   } job_t;
   job_t tbl [5];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
   endtask

   task automatic nxt;
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs;
      chk("rst_job_ready", job_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_start", ntt_start, 0);
      chk("rst_read", ntt_mem_read, 0);
      chk("rst_write", ntt_mem_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_addr", ntt_row_addr, 0);
      chk("rst_mod", ntt_mod_idx, 0);
   endtask

   task automatic do_reset;
      nxt;
      reset = 1; job_valid = 0; in_valid = 0; ntt_done = 0; out_ready = 0;
      nxt;
      reset = 0;
      #1 check_reset_outputs();
   endtask

   // Leaves job_valid high in a cycle where job_ready is seen; the next edge accepts.
   task automatic accept_job(input logic [5:0] m);
      int w = 0;
      do begin
         nxt; job_valid = 1; job_mod_idx = m; #1; w++;
      end while (!job_ready && w < 50);
      chk("job_ready_seen", job_ready, 1);
   endtask

   task automatic load_rows(input int n, input bit gaps, input logic [5:0] m);
      int r = 0, writes = 0, cyc = 0;
      bit v;
      while (r < n && cyc < 200) begin
         nxt;
         job_valid = 0; job_mod_idx = 6'($urandom);
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v; din = v ? host[r] : {$urandom, $urandom};
         #1;
         if (cyc == 0) begin
            chk("load_busy", busy, 1);
            chk("load_mod", ntt_mod_idx, m);
            chk("load_job_ready", job_ready, 0);
         end
         chk("load_in_ready", in_ready, 1);
         chk("load_write", ntt_mem_write, v);
         if (v) begin
            chk("load_addr", ntt_row_addr, r);
            writes++; r++;
         end
         cyc++;
      end
      chk("write_cycles", writes, n);
   endtask

   task automatic start_phase(input bit early, input logic [5:0] m);
      nxt; in_valid = 0; ntt_done = early; #1;
      chk("start_pulse", ntt_start, 1);
      chk("start_mod", ntt_mod_idx, m);
      chk("start_in_ready", in_ready, 0);
      chk("start_write", ntt_mem_write, 0);
   endtask

   task automatic run_phase(input int delay);
      bit quiet = 1;
      for (int i = 0; i < delay; i++) begin
         nxt; ntt_done = 0; #1;
         if (ntt_mem_read || out_valid || ntt_start || !busy || err_timeout) quiet = 0;
      end
      chk("run_quiet", quiet, 1);
      nxt; ntt_done = 1; #1;
   endtask

   task automatic unload_phase(input int mode, input logic [5:0] m, input int exp_rows);
      int k = 0, issued = 0, popped = 0, cyc = 0;
      bit pat [4] = '{1, 0, 0, 1};
      bit prev_stall = 0, prev_l = 0;
      logic [DW-1:0] prev_d = '0;
      while (k < ROWS && cyc < 400) begin
         nxt;
         ntt_done = 0;
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
         #1;
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_d);
            chk("stall_last", out_last, prev_l);
         end
         if (ntt_mem_read) begin
            chk("rd_addr", ntt_row_addr, issued);
            chk("rd_wr_excl", ntt_mem_write, 0);
            issued++;
         end
         if (out_valid && out_ready) begin
            chk("row_data", out_data, host[k] + DW'(m));
            chk("row_last", out_last, (k == ROWS - 1));
            k++; popped++;
         end
         if (ntt_mem_read) chk("occupancy_le2", ((issued - popped) <= 2), 1);
         prev_stall = out_valid && !out_ready;
         prev_d = out_data; prev_l = out_last;
         cyc++;
      end
      chk("rows_out", k, exp_rows);
      chk("reads_total", issued, ROWS);
      nxt; out_ready = 0; #1;
      chk("end_idle", busy, 0);
      chk("end_job_ready", job_ready, 1);
      chk("end_out_valid", out_valid, 0);
   endtask

   task automatic run_job(input job_t j);
      int s0;
      for (int r = 0; r < ROWS; r++) host[r] = {$urandom, $urandom};
      s0 = starts;
      accept_job(j.mod);
      load_rows(ROWS, j.gaps, j.mod);
      start_phase(j.early, j.mod);
      run_phase(j.delay);
      unload_phase(j.rmode, j.mod, j.exp_rows);
      chk("one_start", starts - s0, 1);
      chk("job_err", err_timeout, j.exp_err);
   endtask

   task automatic timeout_test;
      bit bad = 0;
      nxt; b_job_valid = 1; b_job_mod_idx = 6'd3; #1;
      chk("to_job_ready", b_job_ready, 1);
      for (int r = 0; r < ROWS; r++) begin
         nxt; b_job_valid = 0; b_in_valid = 1; #1;
         if (!b_ntt_mem_write) bad = 1;
      end
      chk("to_load", bad, 0);
      nxt; b_in_valid = 0; #1;
      chk("to_start", b_ntt_start, 1);
      for (int i = 1; i <= 20; i++) begin
         nxt; #1;
         if (b_err_timeout || !b_busy || b_out_valid) bad = 1;
      end
      chk("to_run_20", bad, 0);
      nxt; #1;
      chk("to_err_set", b_err_timeout, 1);
      chk("to_idle", b_busy, 0);
      chk("to_no_out", b_out_valid, 0);
      repeat (3) nxt;
      chk("to_err_sticky", b_err_timeout, 1);
      chk("to_no_read", b_ntt_mem_read, 0);
      nxt; b_job_valid = 1; #1;
      nxt; b_job_valid = 0; #1;
      chk("to_err_cleared", b_err_timeout, 0);
      chk("to_busy_again", b_busy, 1);
   endtask

   initial begin
      job_t rj;
      reset = 1; job_valid = 0; job_mod_idx = 0; in_valid = 0; out_ready = 0;
      ntt_done = 0; din = '0;
      b_job_valid = 0; b_job_mod_idx = 0; b_in_valid = 0;
      tbl[0] = '{6'd5,  100, 1'b0, 0, 1'b0, ROWS, 1'b0};
      tbl[1] = '{6'd12, 30,  1'b0, 1, 1'b0, ROWS, 1'b0};
      tbl[2] = '{6'd33, 50,  1'b1, 0, 1'b0, ROWS, 1'b0};
      tbl[3] = '{6'd63, 10,  1'b0, 2, 1'b1, ROWS, 1'b0};
      tbl[4] = '{6'd0,  1,   1'b0, 1, 1'b1, ROWS, 1'b0};

      do_reset();
      timeout_test();

      // Reset after three rows loaded.
      for (int r = 0; r < ROWS; r++) host[r] = {$urandom, $urandom};
      accept_job(6'd7);
      load_rows(3, 1'b0, 6'd7);
      do_reset();

      // Reset mid-unload with both FIFO entries occupied.
      accept_job(6'd9);
      load_rows(ROWS, 1'b0, 6'd9);
      start_phase(1'b0, 6'd9);
      run_phase(5);
      for (int i = 0; i < 6; i++) begin
         nxt; ntt_done = 0; out_ready = 0; #1;
      end
      chk("mid_unload_valid", out_valid, 1);
      do_reset();

      for (int t = 0; t < 5; t++) run_job(tbl[t]);

      for (int t = 0; t < 4; t++) begin
         rj.mod = 6'($urandom_range(0, 63));
         rj.delay = $urandom_range(1, 60);
         rj.early = 1'($urandom_range(0, 1));
         rj.rmode = 2;
         rj.gaps = 1'b1;
         rj.exp_rows = ROWS;
         rj.exp_err = 1'b0;
         run_job(rj);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
